sprite_renderer: RTL and testbench

- Pipelined, parametrised monochrome sprite renderer for the VGA pixel path.
- Per pixel, decides whether the pixel lies inside a WIDTH x HEIGHT bitmap at a programmable screen position, and outputs the bitmap bit.
- Bitmap data comes from an external synchronous ROM holding FRAMES animation frames.
- Adds over the combinational sprite lookup: registered outputs, frame-synchronous position latching, horizontal mirror, 2x scale, and automatic frame animation.

---
 rtl/sprite_if.sv | 33 +++
 rtl/sprite_renderer.sv | 141 ++++++++++++++
 tb/tb_sprite_renderer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_if.sv
// Pixel-path bundle between the timing generator / ROM side and the sprite renderer.
// The master side drives pixel, position and ROM data; the renderer returns ROM address and paint.
interface sprite_if #(
    parameter int WIDTH   = 40,
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 7
);
    logic               frame_start;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               flip_h;
    logic               scale2x;
    logic               anim_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [WIDTH-1:0]   rom_data;
    logic               paint;
    logic               paint_valid;

    modport master (
        output frame_start, pix_valid, pix_x, pix_y, pos_x, pos_y,
               flip_h, scale2x, anim_en, rom_data,
        input  rom_addr, paint, paint_valid
    );

    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, pos_x, pos_y,
               flip_h, scale2x, anim_en, rom_data,
        output rom_addr, paint, paint_valid
    );
endinterface

// File: rtl/sprite_renderer.sv
// Three-stage monochrome sprite renderer: hit test and ROM address, ROM read, bit select.
// Position/flip/scale are shadowed on frame_start; the animation frame advances every ANIM_DIV frames.
module sprite_renderer #(
    parameter int WIDTH    = 40,
    parameter int HEIGHT   = 24,
    parameter int FRAMES   = 4,
    parameter int COORD_W  = 11,
    parameter int ANIM_DIV = 8,
    parameter int ADDR_W   = $clog2(FRAMES*HEIGHT)
) (
    input logic clk,
    input logic rst,
    sprite_if.slave bus
);
    localparam int COL_W = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
    localparam int ROW_W = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1;
    localparam int FRM_W = (FRAMES > 1)   ? $clog2(FRAMES)   : 1;
    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [COORD_W:0] EXT_W1 = (COORD_W+1)'(WIDTH);
    localparam logic [COORD_W:0] EXT_W2 = (COORD_W+1)'(2*WIDTH);
    localparam logic [COORD_W:0] EXT_H1 = (COORD_W+1)'(HEIGHT);
    localparam logic [COORD_W:0] EXT_H2 = (COORD_W+1)'(2*HEIGHT);
    localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(HEIGHT);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(ANIM_DIV-1);
    localparam logic [FRM_W-1:0] FRM_TC = FRM_W'(FRAMES-1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH-1);

    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic               flip_q, scale_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRM_W-1:0]   frame_q;

    // stage 0 (combinational)
    logic [COORD_W:0]   dx, dy, dxs, dys, ext_w, ext_h;
    logic               hit0;
    logic [COL_W-1:0]   col0;
    logic [ROW_W-1:0]   row0;
    logic [ADDR_W-1:0]  addr0;

    // stage 1 / stage 2
    logic               v1, hit1, flip1;
    logic [COL_W-1:0]   col1;
    logic               v2, hit2, flip2;
    logic [COL_W-1:0]   col2;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               paint_q, paint_valid_q;

    logic [COL_W-1:0]   bit_idx;
    logic               bit_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            flip_q  <= 1'b0;
            scale_q <= 1'b0;
        end else if (bus.frame_start) begin
            pos_x_q <= bus.pos_x;
            pos_y_q <= bus.pos_y;
            flip_q  <= bus.flip_h;
            scale_q <= bus.scale2x;
        end
    end

    // Counter sits at zero whenever animation is off, so re-enabling restarts a full ANIM_DIV period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            frame_q <= '0;
        end else if (!bus.anim_en) begin
            cnt_q <= '0;
        end else if (bus.frame_start) begin
            if (cnt_q == CNT_TC) begin
                cnt_q   <= '0;
                frame_q <= (frame_q == FRM_TC) ? '0 : frame_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        dx    = {1'b0, bus.pix_x} - {1'b0, pos_x_q};
        dy    = {1'b0, bus.pix_y} - {1'b0, pos_y_q};
        dxs   = scale_q ? (dx >> 1) : dx;
        dys   = scale_q ? (dy >> 1) : dy;
        ext_w = scale_q ? EXT_W2 : EXT_W1;
        ext_h = scale_q ? EXT_H2 : EXT_H1;
        // Sign bit set means the pixel is left of / above the sprite: no wrap-around hits.
        hit0  = bus.pix_valid && !dx[COORD_W] && !dy[COORD_W] && (dx < ext_w) && (dy < ext_h);
        col0  = hit0 ? COL_W'(dxs) : '0;
        row0  = hit0 ? ROW_W'(dys) : '0;
        addr0 = ADDR_W'(frame_q) * H_A + ADDR_W'(row0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
            v1    <= 1'b0;
            hit1  <= 1'b0;
            flip1 <= 1'b0;
            col1  <= '0;
            v2    <= 1'b0;
            hit2  <= 1'b0;
            flip2 <= 1'b0;
            col2  <= '0;
        end else begin
            rom_addr_q <= addr0;
            v1    <= bus.pix_valid;
            hit1  <= hit0;
            flip1 <= flip_q;
            col1  <= col0;
            v2    <= v1;
            hit2  <= hit1;
            flip2 <= flip1;
            col2  <= col1;
        end
    end

    // Bitmap MSB is the leftmost column; mirroring reads from the LSB side instead.
    always_comb begin
        bit_idx = flip2 ? col2 : (COL_MAX - col2);
        bit_val = bus.rom_data[bit_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paint_q       <= 1'b0;
            paint_valid_q <= 1'b0;
        end else begin
            paint_q       <= hit2 & bit_val;
            paint_valid_q <= v2;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.paint       = paint_q;
    assign bus.paint_valid = paint_valid_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a synchronous ROM whose word at address a is 0xA5_0000_0001 ^ a.
// Expected addresses and paint bits are worked out by hand from that pattern.
module tb_sprite_renderer;
    localparam int WIDTH   = 40;
    localparam int HEIGHT  = 24;
    localparam int FRAMES  = 4;
    localparam int COORD_W = 11;
    localparam int ANIM_DIV = 8;
    localparam int ADDR_W  = 7;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [WIDTH-1:0] rom_base;
    logic [7:0] pat;

    sprite_if #(.WIDTH(WIDTH), .COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

    sprite_renderer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAMES(FRAMES),
        .COORD_W(COORD_W), .ANIM_DIV(ANIM_DIV), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_base = 40'hA5_0000_0001;
    always_ff @(posedge clk) bus.rom_data <= rom_base ^ {{(WIDTH-ADDR_W){1'b0}}, bus.rom_addr};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic latch(input int px, input int py, input logic fl, input logic sc);
        @(posedge clk); #1;
        bus.pos_x = COORD_W'(px);
        bus.pos_y = COORD_W'(py);
        bus.flip_h = fl;
        bus.scale2x = sc;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic pulse_fs(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 bus.frame_start = 1'b1;
            @(posedge clk); #1 bus.frame_start = 1'b0;
        end
    endtask

    // Present one pixel in cycle N; rom_addr checked in N+1, paint/paint_valid in N+3.
    task automatic apply(input string tag, input int x, input int y, input logic fs,
                         input int exp_addr, input logic exp_paint);
        @(posedge clk); #1;
        bus.pix_valid = 1'b1;
        bus.pix_x = COORD_W'(x);
        bus.pix_y = COORD_W'(y);
        bus.frame_start = fs;
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.frame_start = 1'b0;
        chk({tag, "_addr"}, 64'(bus.rom_addr), 64'(exp_addr));
        @(posedge clk);
        @(posedge clk); #1;
        chk({tag, "_paint"}, 64'(bus.paint), 64'(exp_paint));
        chk({tag, "_pv"}, 64'(bus.paint_valid), 64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        bus.flip_h = 1'b0;
        bus.scale2x = 1'b0;
        bus.anim_en = 1'b0;
        pat = 8'b0100_1101;

        #3;
        chk("rst_paint", 64'(bus.paint), 64'd0);
        chk("rst_pv", 64'(bus.paint_valid), 64'd0);
        chk("rst_addr", 64'(bus.rom_addr), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // basic
        latch(100, 50, 1'b0, 1'b0);
        apply("b_tl",   100, 50, 1'b0, 0,  1'b1);
        apply("b_br",   139, 73, 1'b0, 23, 1'b0);
        apply("b_r22",  139, 72, 1'b0, 22, 1'b1);
        apply("b_miss", 140, 50, 1'b0, 0,  1'b0);
        apply("b_c2",   102, 51, 1'b0, 1,  1'b1);
        apply("b_c1",   101, 50, 1'b0, 0,  1'b0);

        // mirror
        latch(100, 50, 1'b1, 1'b0);
        apply("m_c0",   100, 50, 1'b0, 0, 1'b1);
        apply("m_c39",  139, 50, 1'b0, 0, 1'b1);
        apply("m_c1",   101, 50, 1'b0, 0, 1'b0);
        apply("m_r2",   101, 52, 1'b0, 2, 1'b1);

        // scale
        latch(100, 50, 1'b0, 1'b1);
        apply("s_br",   179, 97, 1'b0, 23, 1'b0);
        apply("s_r22",  179, 95, 1'b0, 22, 1'b1);
        apply("s_mx",   180, 50, 1'b0, 0,  1'b0);
        apply("s_my",   100, 98, 1'b0, 0,  1'b0);
        apply("s_tl",   101, 51, 1'b0, 0,  1'b1);
        apply("s_c2",   104, 50, 1'b0, 0,  1'b1);
        apply("s_c1",   102, 50, 1'b0, 0,  1'b0);

        // right-edge clipping, no wrap, ignored unlatched position change
        latch(2040, 10, 1'b0, 1'b0);
        apply("e_c7",   2047, 10, 1'b0, 0, 1'b1);
        apply("e_c6",   2046, 11, 1'b0, 1, 1'b0);
        apply("e_wrap", 0,    10, 1'b0, 0, 1'b0);
        bus.pos_x = '0;
        apply("e_nolat0", 0,    10, 1'b0, 0, 1'b0);
        apply("e_nolat1", 2047, 10, 1'b0, 0, 1'b1);
        bus.pos_x = COORD_W'(100);
        bus.pos_y = COORD_W'(50);
        apply("e_fs_old", 2047, 10, 1'b1, 0, 1'b1);
        apply("e_fs_new", 100,  50, 1'b0, 0, 1'b1);

        // bubbles: paint_valid follows pix_valid three cycles later
        bus.pix_x = COORD_W'(100);
        bus.pix_y = COORD_W'(50);
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (c >= 3) begin
                chk("bub_pv", 64'(bus.paint_valid), 64'(pat[c-3]));
                chk("bub_paint", 64'(bus.paint), 64'(pat[c-3]));
            end
            bus.pix_valid = (c < 8) ? pat[c] : 1'b0;
        end
        bus.pix_valid = 1'b0;

        // animation
        bus.anim_en = 1'b1;
        pulse_fs(8);
        apply("a_f1", 100, 50, 1'b0, 24, 1'b1);
        pulse_fs(24);
        apply("a_wrap", 100, 50, 1'b0, 0, 1'b1);
        pulse_fs(8);
        apply("a_f1b", 100, 50, 1'b0, 24, 1'b1);
        bus.anim_en = 1'b0;
        pulse_fs(20);
        apply("a_hold", 100, 50, 1'b0, 24, 1'b1);

        // reset with pixels in flight
        @(posedge clk); #1 bus.pix_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.pix_valid = 1'b0;
        chk("r_pre_pv", 64'(bus.paint_valid), 64'd1);
        chk("r_pre_paint", 64'(bus.paint), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("r_paint", 64'(bus.paint), 64'd0);
        chk("r_pv", 64'(bus.paint_valid), 64'd0);
        chk("r_addr", 64'(bus.rom_addr), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("r_hold_pv", 64'(bus.paint_valid), 64'd0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("r_idle_pv", 64'(bus.paint_valid), 64'd0);
            chk("r_idle_paint", 64'(bus.paint), 64'd0);
        end
        apply("r_p00", 0, 0, 1'b0, 0, 1'b1);
        apply("r_p10", 1, 0, 1'b0, 0, 1'b0);
        apply("r_p01", 0, 1, 1'b0, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
